// File: rtl/sie_defs_pkg.sv
// Shared USB SIE definitions: PID codes and classes, SYNC/CRC5 constants, line states
// and the host transmitter FSM state type.
package sie_defs_pkg;

  typedef enum logic [3:0] {
    PID_RSVD  = 4'b0000, PID_OUT   = 4'b0001, PID_ACK   = 4'b0010, PID_DATA0 = 4'b0011,
    PID_PING  = 4'b0100, PID_SOF   = 4'b0101, PID_NYET  = 4'b0110, PID_DATA2 = 4'b0111,
    PID_SPLIT = 4'b1000, PID_IN    = 4'b1001, PID_NAK   = 4'b1010, PID_DATA1 = 4'b1011,
    PID_PRE   = 4'b1100, PID_SETUP = 4'b1101, PID_STALL = 4'b1110, PID_MDATA = 4'b1111
  } pid_t;

  localparam logic [1:0] PID_CLASS_TOKEN     = 2'b01;
  localparam logic [1:0] PID_CLASS_HANDSHAKE = 2'b10;

  localparam logic [7:0] SYNC_PATTERN = 8'b1000_0000;
  localparam logic [4:0] CRC5_POLY    = 5'b00101;
  localparam logic [4:0] CRC5_INIT    = 5'b11111;

  typedef enum logic [1:0] {LINE_J, LINE_K, LINE_SE0} line_state_t;

  typedef enum logic [1:0] {EOP_NONE, EOP_SE0, EOP_J} eop_req_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SYNC, ST_PID, ST_PAYLOAD, ST_CRC, ST_EOP_SE0, ST_EOP_J, ST_DONE
  } tx_state_t;

  // CRC5 register over an 11-bit field, LSb first; caller complements before sending
  function automatic logic [4:0] crc5(input logic [10:0] data);
    logic [4:0] c;
    c = CRC5_INIT;
    for (int unsigned i = 0; i < 11; i++) begin
      if (data[i] ^ c[4]) c = {c[3:0], 1'b0} ^ CRC5_POLY;
      else                c = {c[3:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/usb_host_token_tx_if.sv
// Request/status and line-drive bundle of the host token/handshake transmitter.
// Macro USB_HOST_TX_CRC_INJECT_EN adds the injectCrcErr request field.
interface usb_host_token_tx_if;
  logic        reqSend;
  logic [3:0]  pid;
  logic [10:0] payload;
`ifdef USB_HOST_TX_CRC_INJECT_EN
  logic        injectCrcErr;
`endif
  logic        busy;
  logic        done;
  logic        reqError;
  logic        outEN;
  logic        dataOutP;
  logic        dataOutN;

  modport master (
`ifdef USB_HOST_TX_CRC_INJECT_EN
    output injectCrcErr,
`endif
    output reqSend, pid, payload,
    input  busy, done, reqError, outEN, dataOutP, dataOutN
  );

  modport slave (
`ifdef USB_HOST_TX_CRC_INJECT_EN
    input  injectCrcErr,
`endif
    input  reqSend, pid, payload,
    output busy, done, reqError, outEN, dataOutP, dataOutN
  );
endinterface

// File: rtl/usb_tx_line_enc.sv
// USB line encoder: bit stuffing, NRZI and J/K/SE0 pin drive, one symbol per strobe.
// stall is high while the next strobe will emit a stuff bit instead of data_bit.
module usb_tx_line_enc
  import sie_defs_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     strobe,
  input  logic     data_bit,
  input  eop_req_t eop,
  output logic     stall,
  output logic     dp,
  output logic     dn
);

  line_state_t line;
  logic [2:0]  ones;

  assign stall = (ones == 3'd6);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line <= LINE_J;
      ones <= '0;
    end else if (strobe) begin
      if (stall || (eop == EOP_NONE && !data_bit)) begin
        line <= (line == LINE_J) ? LINE_K : LINE_J;
        ones <= '0;
      end else if (eop == EOP_SE0) begin
        line <= LINE_SE0;
        ones <= '0;
      end else if (eop == EOP_J) begin
        line <= LINE_J;
        ones <= '0;
      end else begin
        ones <= ones + 3'd1;
      end
    end
  end

  assign dp = (line == LINE_J);
  assign dn = (line == LINE_K);

endmodule

// File: rtl/usb_host_token_tx.sv
// Full-speed USB host TOKEN/HANDSHAKE transmitter: SYNC, PID, payload, CRC5, EOP.
// Optional macro USB_HOST_TX_CRC_INJECT_EN enables deliberate CRC corruption.
module usb_host_token_tx
  import sie_defs_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input logic               clk48,
  input logic               RST_N,
  usb_host_token_tx_if.slave bus
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  tx_state_t   state, state_nxt, succ_state, pos_state;
  logic [3:0]  idx, idx_nxt, succ_idx, pos_idx;
  logic [CW-1:0] cnt;
  logic [3:0]  pid_q;
  logic [10:0] payload_q;
  logic [4:0]  crc_tx;
  logic        busy, good_class, start, bit_end, advance, stall, tx_bit, is_token;
  logic        req_error;
  eop_req_t    eop;

  assign busy       = (state != ST_IDLE) && (state != ST_DONE);
  assign good_class = (bus.pid[1:0] == PID_CLASS_TOKEN) || (bus.pid[1:0] == PID_CLASS_HANDSHAKE);
  assign start      = bus.reqSend && !busy && good_class;
  assign bit_end    = busy && (cnt == CW'(CLKS_PER_BIT - 1));
  assign advance    = start || (bit_end && !stall);
  assign is_token   = (pid_q[1:0] == PID_CLASS_TOKEN);

`ifdef USB_HOST_TX_CRC_INJECT_EN
  logic inject_q;
  always_ff @(posedge clk48 or negedge RST_N) begin
    if (!RST_N)     inject_q <= 1'b0;
    else if (start) inject_q <= bus.injectCrcErr;
  end
  assign crc_tx = ~crc5(payload_q) ^ {4'b0000, inject_q};
`else
  assign crc_tx = ~crc5(payload_q);
`endif

  always_ff @(posedge clk48 or negedge RST_N) begin
    if (!RST_N) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_ff @(posedge clk48 or negedge RST_N) begin
    if (!RST_N) begin
      cnt       <= '0;
      pid_q     <= '0;
      payload_q <= '0;
      req_error <= 1'b0;
    end else begin
      req_error <= bus.reqSend && !busy && !good_class;
      if (start) begin
        cnt       <= '0;
        pid_q     <= bus.pid;
        payload_q <= bus.payload;
      end else if (busy) begin
        cnt <= bit_end ? '0 : cnt + CW'(1);
      end
    end
  end

  // pos_* is the symbol the encoder emits on this strobe; a stuff bit holds the FSM in place
  always_comb begin
    succ_state = state;
    succ_idx   = idx + 4'd1;
    unique case (state)
      ST_SYNC:    if (idx == 4'd7)  begin succ_state = ST_PID; succ_idx = '0; end
      ST_PID:     if (idx == 4'd7)  begin succ_state = is_token ? ST_PAYLOAD : ST_EOP_SE0; succ_idx = '0; end
      ST_PAYLOAD: if (idx == 4'd10) begin succ_state = ST_CRC; succ_idx = '0; end
      ST_CRC:     if (idx == 4'd4)  begin succ_state = ST_EOP_SE0; succ_idx = '0; end
      ST_EOP_SE0: if (idx == 4'd1)  begin succ_state = ST_EOP_J; succ_idx = '0; end
      ST_EOP_J:   begin succ_state = ST_DONE; succ_idx = '0; end
      default:    begin succ_state = state; succ_idx = idx; end
    endcase

    pos_state = start ? ST_SYNC : succ_state;
    pos_idx   = start ? 4'd0 : succ_idx;
    state_nxt = advance ? pos_state : ((state == ST_DONE) ? ST_IDLE : state);
    idx_nxt   = advance ? pos_idx : idx;

    tx_bit = 1'b0;
    eop    = EOP_NONE;
    unique case (pos_state)
      ST_SYNC:    tx_bit = SYNC_PATTERN[pos_idx[2:0]];
      ST_PID:     tx_bit = pos_idx[3] ? 1'b0 : (pos_idx[2] ? ~pid_q[pos_idx[1:0]] : pid_q[pos_idx[1:0]]);
      ST_PAYLOAD: tx_bit = payload_q[pos_idx];
      ST_CRC:     tx_bit = crc_tx[3'd4 - pos_idx[2:0]];
      ST_EOP_SE0: eop = EOP_SE0;
      ST_EOP_J, ST_DONE: eop = EOP_J;
      default:    eop = EOP_NONE;
    endcase
  end

  usb_tx_line_enc u_line_enc (
    .clk      (clk48),
    .rst_n    (RST_N),
    .strobe   (start || bit_end),
    .data_bit (tx_bit),
    .eop      (eop),
    .stall    (stall),
    .dp       (bus.dataOutP),
    .dn       (bus.dataOutN)
  );

  assign bus.busy     = busy;
  assign bus.outEN    = busy;
  assign bus.done     = (state == ST_DONE);
  assign bus.reqError = req_error;

endmodule

// File: tb/tb_usb_host_token_tx.sv
// Directed bench for usb_host_token_tx: captures the line, NRZI-decodes and destuffs it,
// and compares packet bytes, timing and EOP against hand-computed values.
module tb_usb_host_token_tx;
  import sie_defs_pkg::*;

  logic clk48 = 1'b0;
  logic RST_N;

  usb_host_token_tx_if bus ();

  usb_host_token_tx #(.CLKS_PER_BIT(4)) dut (
    .clk48 (clk48),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 clk48 = ~clk48;

  int errors = 0;
  int checks = 0;

  logic [2:0]  samp [0:399];   // {outEN, dataOutP, dataOutN} per cycle from busy rise
  int          dur;
  logic        rerr_seen;
  logic        oe_ok;
  logic [39:0] bitbuf;
  int          nbits, nstuff;
  logic        stuff_bad;
  logic [7:0]  sync_k;
  logic [5:0]  eop_code;
  int          eop_end;
  logic        seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Request at one negedge; next negedge is the first busy cycle, inputs then scrambled
  task automatic send(input logic [3:0] p, input logic [10:0] pl);
    @(negedge clk48);
    bus.reqSend = 1'b1; bus.pid = p; bus.payload = pl;
    @(negedge clk48);
    bus.reqSend = 1'b0; bus.pid = ~p; bus.payload = ~pl;
  endtask

  task automatic capture(input int poke_at);
    dur = -1; rerr_seen = 1'b0; oe_ok = 1'b1;
    for (int i = 0; i < 400; i++) begin
      samp[i] = {bus.outEN, bus.dataOutP, bus.dataOutN};
      if (bus.reqError) rerr_seen = 1'b1;
      if (bus.done) begin dur = i; break; end
      if (!bus.outEN) oe_ok = 1'b0;
      bus.reqSend = (i == poke_at);
      @(negedge clk48);
    end
    bus.reqSend = 1'b0;
    if (dur < 0) begin
      chk("done_timeout", 32'd0, 32'd1);
      dur = 0;
    end
  endtask

  task automatic decode();
    logic [1:0] prev, sym;
    int ones, k, nsym;
    logic b;
    prev = 2'b10; ones = 0; nbits = 0; nstuff = 0; stuff_bad = 1'b0;
    sync_k = '0; bitbuf = '0; eop_code = '1; eop_end = -1;
    nsym = dur / 4;
    k = 0;
    while (k < nsym) begin
      sym = samp[4*k+2][1:0];
      if (k < 8) sync_k[k] = (sym == 2'b01);
      if (sym == 2'b00) break;
      b = (sym == prev);
      prev = sym;
      if (ones == 6) begin
        nstuff++;
        if (b) stuff_bad = 1'b1;
        ones = 0;
      end else begin
        if (nbits < 40) bitbuf[nbits] = b;
        nbits++;
        ones = b ? ones + 1 : 0;
      end
      k++;
    end
    if (k + 2 < nsym) begin
      eop_code = {samp[4*k+2][1:0], samp[4*k+6][1:0], samp[4*k+10][1:0]};
      eop_end  = k + 3;
    end
  endtask

  initial begin
    RST_N = 1'b0;
    bus.reqSend = 1'b0; bus.pid = '0; bus.payload = '0;
`ifdef USB_HOST_TX_CRC_INJECT_EN
    bus.injectCrcErr = 1'b0;
`endif
    #1;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_reqError", bus.reqError, 1'b0);
    chk("rst_outEN", bus.outEN, 1'b0);
    chk("rst_dataOutP", bus.dataOutP, 1'b1);
    chk("rst_dataOutN", bus.dataOutN, 1'b0);
    repeat (2) @(negedge clk48);
    RST_N = 1'b1;

    // SETUP, addr/endp 0; a reqSend poke mid-packet must be ignored
    send(4'b1101, 11'h000);
    chk("setup_busy_rise", bus.busy, 1'b1);
    capture(20);
    decode();
    chk("setup_cycles", dur, 140);
    chk("setup_sync", bitbuf[7:0], 8'h80);
    chk("setup_pid", bitbuf[15:8], 8'h2D);
    chk("setup_byte1", bitbuf[23:16], 8'h00);
    chk("setup_byte2", bitbuf[31:24], 8'h10);
    chk("setup_nbits", nbits, 32);
    chk("setup_nstuff", nstuff, 0);
    chk("setup_eop", eop_code, 6'b00_00_10);
    chk("setup_eop_last", eop_end, 35);
    chk("setup_outEN_held", oe_ok, 1'b1);
    chk("setup_outEN_off", samp[dur][2], 1'b0);
    chk("setup_no_reqError", rerr_seen, 1'b0);
    @(negedge clk48);
    chk("setup_done_pulse", bus.done, 1'b0);
    chk("setup_not_queued", bus.busy, 1'b0);

    // IN: check the NRZI SYNC pattern on the line
    send(4'b1001, 11'h000);
    capture(-1);
    decode();
    chk("in_sync_line", sync_k, 8'hD5);
    chk("in_pid", bitbuf[15:8], 8'h69);
    chk("in_byte1", bitbuf[23:16], 8'h00);
    chk("in_byte2", bitbuf[31:24], 8'h10);
    chk("in_cycles", dur, 140);

    // ACK handshake: PID only, then EOP
    send(4'b0010, 11'h5A5);
    capture(-1);
    decode();
    chk("ack_cycles", dur, 76);
    chk("ack_pid", bitbuf[15:8], 8'hD2);
    chk("ack_nbits", nbits, 16);
    chk("ack_eop", eop_code, 6'b00_00_10);
    @(negedge clk48);
    chk("ack_done_pulse", bus.done, 1'b0);

    // SOF frame 0x7FF: two stuff bits, CRC5 0b11101 sent complemented
    send(4'b0101, 11'h7FF);
    capture(-1);
    decode();
    chk("sof_cycles", dur, 148);
    chk("sof_nstuff", nstuff, 2);
    chk("sof_stuff_toggles", stuff_bad, 1'b0);
    chk("sof_pid", bitbuf[15:8], 8'hA5);
    chk("sof_byte1", bitbuf[23:16], 8'hFF);
    chk("sof_byte2", bitbuf[31:24], 8'h47);
    chk("sof_eop", eop_code, 6'b00_00_10);

    // DATA0 is not a transmittable class here
    @(negedge clk48);
    bus.reqSend = 1'b1; bus.pid = 4'b0011; bus.payload = '0;
    @(negedge clk48);
    bus.reqSend = 1'b0;
    chk("bad_reqError", bus.reqError, 1'b1);
    chk("bad_busy", bus.busy, 1'b0);
    chk("bad_outEN", bus.outEN, 1'b0);
    @(negedge clk48);
    chk("bad_reqError_pulse", bus.reqError, 1'b0);

    // Asynchronous reset mid-SETUP
    send(4'b1101, 11'h000);
    repeat (49) @(negedge clk48);
    chk("abort_busy_before", bus.busy, 1'b1);
    #2 RST_N = 1'b0;
    #1;
    chk("abort_outEN", bus.outEN, 1'b0);
    chk("abort_dataOutP", bus.dataOutP, 1'b1);
    chk("abort_dataOutN", bus.dataOutN, 1'b0);
    chk("abort_busy", bus.busy, 1'b0);
    @(negedge clk48);
    RST_N = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk48);
      if (bus.done || bus.busy || bus.outEN) seen = 1'b1;
    end
    chk("abort_no_done", seen, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
